alu_share_arb: RTL and testbench
================================

ALU_SHARE_ARB -- requirements
Module: alu_share_arb

Interface
REQ-001 WIDTH, 32, operand/result width.
REQ-002 OPW, 7, opcode width.
REQ-003 FLW, 5, flag vector width.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req0_valid/req1_valid  input  1  requester n presents an operation.
REQ-007 req0_ready/req1_ready  output  1  requester n operation accepted this cycle.
REQ-008 req0_a, req0_b, req1_a, req1_b  input  WIDTH  operands.
REQ-009 req0_op, req1_op  input  OPW  opcode.
REQ-010 alu_a, alu_b  output  WIDTH  registered operands to the shared ALU.
REQ-011 alu_op  output  OPW  registered opcode to the shared ALU.
REQ-012 alu_out  input  WIDTH  combinational ALU result.
REQ-013 alu_carry  input  1 and alu_flags  input  FLW  ALU carry and flags.
REQ-014 rsp_valid  output  1  response held; rsp_ready  input  1  consumer accepts.
REQ-015 rsp_id  output  1  requester that issued the response (0/1).
REQ-016 rsp_data  output  WIDTH, rsp_carry  output  1, rsp_flags  output  FLW  captured ALU outputs.

Function
REQ-017 FSM states IDLE, EXEC, RESP; reset state IDLE.
REQ-018 IDLE: if any reqN_valid, assert reqN_ready combinationally for the granted requester only, latch its a/b/op into alu_a/alu_b/alu_op and grant id, go EXEC; else stay IDLE.
REQ-019 reqN_ready SHALL be 0 in EXEC and RESP and for the non-granted requester.
REQ-020 Arbitration: single valid wins; both valid -> requester not granted last (round-robin via last_grant register).
REQ-021 EXEC lasts exactly one cycle; on its closing edge capture alu_out, alu_carry, alu_flags, grant id into rsp_* and go RESP.
REQ-022 RESP: rsp_valid=1, rsp_* stable until rsp_valid&&rsp_ready edge, then IDLE.
REQ-023 Latency accept->rsp_valid = 2 cycles; minimum issue interval 3 cycles with rsp_ready tied high.
REQ-024 alu_a/alu_b/alu_op hold last issued values outside EXEC; no arithmetic performed in this block.
REQ-025 Requests arriving while busy stall (ready=0); requester SHALL hold valid and payload until ready.

Reset
REQ-026 Asynchronous rst forces: state IDLE, rsp_valid 0, rsp_id 0, rsp_data/rsp_carry/rsp_flags 0, alu_a/alu_b/alu_op 0, last_grant 1 (requester 0 wins first tie).
REQ-027 rst in EXEC or RESP discards the in-flight operation; no response is produced for it.

Configuration
REQ-028 Macro ALU_ARB_FIXED_PRIO_EN: defined -> requester 0 always wins ties, last_grant unused; undefined -> round-robin per REQ-020.

Verification
REQ-029 Reset, req0 a=5 b=3 op=1 alone, rsp_ready=1 -> req0_ready in cycle 0, rsp_valid in cycle 2 with rsp_id=0, rsp_data = ALU model result.
REQ-030 Both valid every cycle, 4 ops -> grants 0,1,0,1 (round-robin); with ALU_ARB_FIXED_PRIO_EN -> 0,0,0,0.
REQ-031 rsp_ready=0 for 5 cycles in RESP -> rsp_* unchanged, both readys 0, req1 valid stalls; after release next grant issues.
REQ-032 Assert rst during EXEC -> rsp_valid 0, all outputs zero next edge, no response for dropped op.
REQ-033 Sweep opcode 0..14 with random A/B through req1 -> each rsp_data/rsp_carry/rsp_flags matches direct ALU evaluation of latched operands.

Source files
------------

// File: rtl/alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arb
// Description : Two-requester arbiter in front of one shared, external,
//               combinational ALU. A granted operation is registered onto
//               alu_a/alu_b/alu_op, the ALU settles for one cycle (EXEC),
//               its result/carry/flags are captured into a response register
//               that is held until the consumer takes it (RESP).
//               Accept -> rsp_valid latency is 2 cycles; the minimum issue
//               interval is 3 cycles.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Configuration macro:
//   ALU_ARB_FIXED_PRIO_EN  defined   : requester 0 always wins a tie.
//                          undefined : round-robin on ties (last_grant reg).
// ----------------------------------------------------------------------------
// Ports:
//   clk, rst                        clock, async active-high reset
//   req0_valid/req1_valid           requester presents an operation
//   req0_ready/req1_ready           operation accepted this cycle
//   req0_a/b, req1_a/b, reqN_op     operands and opcode
//   alu_a, alu_b, alu_op            registered operands to the shared ALU
//   alu_out, alu_carry, alu_flags   combinational ALU result
//   rsp_valid/rsp_ready             response handshake
//   rsp_id                          requester that issued the response
//   rsp_data, rsp_carry, rsp_flags  captured ALU outputs
// ============================================================================
module alu_share_arb #(
  parameter int WIDTH = 32,
  parameter int OPW   = 7,
  parameter int FLW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry,
  input  logic [FLW-1:0]   alu_flags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_carry,
  output logic [FLW-1:0]   rsp_flags
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic             w_accept;
  logic             w_grant;       // 0 = requester 0, 1 = requester 1
  logic             w_tie_winner;  // who wins when both are valid

  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [OPW-1:0]   r_alu_op;
  logic             r_grant_id;    // id of the operation currently in flight
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_carry;
  logic [FLW-1:0]   r_rsp_flags;

  // --------------------------------------------------------------------------
  // Tie-break policy
  // --------------------------------------------------------------------------
`ifdef ALU_ARB_FIXED_PRIO_EN
  assign w_tie_winner = 1'b0;
`else
  logic r_last_grant;

  // Resets to 1 so requester 0 wins the first tie after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= 1'b1;
    end else if (w_accept) begin
      r_last_grant <= w_grant;
    end
  end

  assign w_tie_winner = ~r_last_grant;
`endif

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state, arbitration and ready outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_grant      = 1'b0;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req0_valid || req1_valid) begin
          w_accept = 1'b1;
          if (req0_valid && req1_valid) begin
            w_grant = w_tie_winner;
          end else begin
            w_grant = req1_valid;
          end
          req0_ready   = ~w_grant;
          req1_ready   = w_grant;
          w_state_next = ST_EXEC;
        end
      end
      // The shared ALU gets exactly one cycle to settle on the registered
      // operands before its outputs are captured.
      ST_EXEC: w_state_next = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Operand issue registers: loaded only on accept, otherwise they keep the
  // last issued operation.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_op   <= '0;
      r_grant_id <= 1'b0;
    end else if (w_accept) begin
      r_alu_a    <= w_grant ? req1_a  : req0_a;
      r_alu_b    <= w_grant ? req1_b  : req0_b;
      r_alu_op   <= w_grant ? req1_op : req0_op;
      r_grant_id <= w_grant;
    end
  end

  // --------------------------------------------------------------------------
  // Response capture on the closing edge of EXEC; held through RESP.
  // A reset during EXEC clears everything, so the dropped operation never
  // produces a response.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_id    <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_carry <= 1'b0;
      r_rsp_flags <= '0;
    end else if (r_state == ST_EXEC) begin
      r_rsp_id    <= r_grant_id;
      r_rsp_data  <= alu_out;
      r_rsp_carry <= alu_carry;
      r_rsp_flags <= alu_flags;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_op    = r_alu_op;
  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign rsp_carry = r_rsp_carry;
  assign rsp_flags = r_rsp_flags;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_share_arb
// Description : Self-checking bench for alu_share_arb. Provides a reference
//               combinational ALU, drives directed and random traffic, and
//               compares every DUT output each cycle against a
//               transaction-level model (accept time, +2 response, release
//               on handshake). Honours ALU_ARB_FIXED_PRIO_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_arb;

  localparam int WIDTH = 32;
  localparam int OPW   = 7;
  localparam int FLW   = 5;

  logic             clk;
  logic             rst;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [OPW-1:0]   req0_op, req1_op;
  logic [WIDTH-1:0] alu_a, alu_b, alu_out;
  logic [OPW-1:0]   alu_op;
  logic             alu_carry;
  logic [FLW-1:0]   alu_flags;
  logic             rsp_valid, rsp_ready, rsp_id, rsp_carry;
  logic [WIDTH-1:0] rsp_data;
  logic [FLW-1:0]   rsp_flags;

  alu_share_arb #(.WIDTH(WIDTH), .OPW(OPW), .FLW(FLW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_out    (alu_out),
    .alu_carry  (alu_carry),
    .alu_flags  (alu_flags),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_carry  (rsp_carry),
    .rsp_flags  (rsp_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Reference ALU: returns {data, carry, flags}; flags = {ovf, parity, carry,
  // negative, zero}.
  // --------------------------------------------------------------------------
  function automatic logic [WIDTH+FLW:0] alu_eval(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic [OPW-1:0] op);
    logic [WIDTH:0]   wide;
    logic [WIDTH-1:0] r;
    logic             c, v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      7'd0: begin
        wide = {1'b0, a} + {1'b0, b};
        r = wide[WIDTH-1:0]; c = wide[WIDTH];
        v = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      7'd1: begin
        wide = {1'b0, a} - {1'b0, b};
        r = wide[WIDTH-1:0]; c = wide[WIDTH];
        v = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      7'd2:  r = a & b;
      7'd3:  r = a | b;
      7'd4:  r = a ^ b;
      7'd5:  r = a << b[4:0];
      7'd6:  r = a >> b[4:0];
      7'd7:  r = $unsigned($signed(a) >>> b[4:0]);
      7'd8:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      7'd9:  r = (a < b) ? 32'd1 : 32'd0;
      7'd10: r = a * b;
      7'd11: r = ~a;
      7'd12: r = b;
      7'd13: r = ~(a & b);
      7'd14: r = (a << b[4:0]) | (a >> (6'd32 - {1'b0, b[4:0]}));
      default: r = '0;
    endcase
    return {r, c, v, ^r, c, r[WIDTH-1], (r == '0)};
  endfunction

  always_comb {alu_out, alu_carry, alu_flags} = alu_eval(alu_a, alu_b, alu_op);

  // --------------------------------------------------------------------------
  // Bookkeeping
  // --------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Transaction-level model: an accepted op occupies the block; its response
  // is visible from accept+2 until the cycle rsp_ready is seen; the block is
  // free again the cycle after.
  // --------------------------------------------------------------------------
  int               cyc = 0;
  bit               m_has;
  int               m_acc;
  bit               m_id;
  bit               m_last;
  logic [WIDTH-1:0] m_alu_a, m_alu_b;
  logic [OPW-1:0]   m_alu_op;
  bit               m_rid;
  logic [WIDTH-1:0] m_rd;
  bit               m_rc;
  logic [FLW-1:0]   m_rf;
  bit               acc0, acc1;
  int               ids_q[$];

  task automatic model_reset();
    m_has = 0; m_acc = 0; m_id = 0; m_last = 1;
    m_alu_a = '0; m_alu_b = '0; m_alu_op = '0;
    m_rid = 0; m_rd = '0; m_rc = 0; m_rf = '0;
  endtask

  initial model_reset();

  always @(negedge clk) begin
    bit free, g, e0, e1, erv;
    logic [WIDTH+FLW:0] res;
    cyc++;
    if (rst) model_reset();
    free = !m_has;
    if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      g = 1'b0;
`else
      g = !m_last;
`endif
    end else begin
      g = req1_valid;
    end
    e0  = free && req0_valid && !g;
    e1  = free && req1_valid && g;
    erv = m_has && (cyc >= m_acc + 2);
    chk("req0_ready", 64'(req0_ready), 64'(e0));
    chk("req1_ready", 64'(req1_ready), 64'(e1));
    chk("rsp_valid",  64'(rsp_valid),  64'(erv));
    chk("rsp_id",     64'(rsp_id),     64'(m_rid));
    chk("rsp_data",   64'(rsp_data),   64'(m_rd));
    chk("rsp_carry",  64'(rsp_carry),  64'(m_rc));
    chk("rsp_flags",  64'(rsp_flags),  64'(m_rf));
    chk("alu_a",      64'(alu_a),      64'(m_alu_a));
    chk("alu_b",      64'(alu_b),      64'(m_alu_b));
    chk("alu_op",     64'(alu_op),     64'(m_alu_op));
    acc0 = !rst && req0_valid && req0_ready;
    acc1 = !rst && req1_valid && req1_ready;
    if (!rst) begin
      if (rsp_valid && rsp_ready) ids_q.push_back(int'(rsp_id));
      if (erv && rsp_ready) begin
        m_has = 0;
      end else if (m_has && cyc == m_acc + 1) begin
        res   = alu_eval(m_alu_a, m_alu_b, m_alu_op);
        m_rd  = res[WIDTH+FLW:FLW+1];
        m_rc  = res[FLW];
        m_rf  = res[FLW-1:0];
        m_rid = m_id;
      end else if (free && (req0_valid || req1_valid)) begin
        m_has = 1; m_acc = cyc; m_id = g; m_last = g;
        m_alu_a  = g ? req1_a  : req0_a;
        m_alu_b  = g ? req1_b  : req0_b;
        m_alu_op = g ? req1_op : req0_op;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  bit auto_drv = 0;
  int p0 = 50, p1 = 50, prr = 100;

  // Advance to just after the next rising edge; in auto mode refresh any
  // requester that is idle or was just accepted (payload held otherwise).
  task automatic step();
    @(posedge clk);
    #1;
    if (auto_drv) begin
      if (!req0_valid || acc0) begin
        req0_valid = ($urandom_range(99) < p0);
        req0_a = $urandom; req0_b = $urandom; req0_op = 7'($urandom_range(15));
      end
      if (!req1_valid || acc1) begin
        req1_valid = ($urandom_range(99) < p1);
        req1_a = $urandom; req1_b = $urandom; req1_op = 7'($urandom_range(15));
      end
      rsp_ready = ($urandom_range(99) < prr);
    end
  endtask

  task automatic do_reset();
    auto_drv = 0;
    step();
    rst = 1; req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    step();
    step();
    rst = 0;
  endtask

  int exp_ids[4];
  logic [WIDTH-1:0] snap;

  initial begin
    int n;
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_ids = '{0, 0, 0, 0};
`else
    exp_ids = '{0, 1, 0, 1};
`endif
    rst = 1; req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    do_reset();

    // Single request: 5 - 3 via requester 0.
    step();
    req0_valid = 1; req0_a = 32'd5; req0_b = 32'd3; req0_op = 7'd1; rsp_ready = 1;
    @(negedge clk); chk("basic_ready_c0", 64'(req0_ready), 64'd1);
    step(); req0_valid = 0;
    @(negedge clk); chk("basic_rspv_c1", 64'(rsp_valid), 64'd0);
    step();
    @(negedge clk);
    chk("basic_rspv_c2",  64'(rsp_valid), 64'd1);
    chk("basic_id",       64'(rsp_id),    64'd0);
    chk("basic_data",     64'(rsp_data),  64'd2);
    chk("basic_carry",    64'(rsp_carry), 64'd0);
    chk("basic_flags",    64'(rsp_flags), 64'h08);
    step();
    @(negedge clk); chk("basic_rspv_c3", 64'(rsp_valid), 64'd0);

    // Both valid every cycle: grant order.
    do_reset();
    ids_q.delete();
    p0 = 100; p1 = 100; prr = 100; auto_drv = 1;
    n = 0;
    while (ids_q.size() < 4 && n < 60) begin step(); n++; end
    chk("rr_timeout", 64'(ids_q.size() >= 4), 64'd1);
    for (int i = 0; i < 4; i++)
      if (i < ids_q.size()) chk($sformatf("grant_%0d", i), 64'(ids_q[i]), 64'(exp_ids[i]));

    // Response back-pressure with requester 1 waiting.
    do_reset();
    step();
    req0_valid = 1; req0_a = $urandom; req0_b = $urandom; req0_op = 7'd0;
    req1_valid = 1; req1_a = $urandom; req1_b = $urandom; req1_op = 7'd4;
    rsp_ready = 0;
    @(negedge clk);
    chk("stall_r0_c0", 64'(req0_ready), 64'd1);
    chk("stall_r1_c0", 64'(req1_ready), 64'd0);
    step(); req0_valid = 0;
    @(negedge clk); chk("stall_r1_exec", 64'(req1_ready), 64'd0);
    step();
    @(negedge clk); snap = rsp_data;
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge clk);
      chk("stall_rspv",   64'(rsp_valid), 64'd1);
      chk("stall_r1",     64'(req1_ready), 64'd0);
      chk("stall_stable", 64'(rsp_data),  64'(snap));
    end
    step(); rsp_ready = 1;
    @(negedge clk); chk("stall_release_v", 64'(rsp_valid), 64'd1);
    step();
    @(negedge clk); chk("stall_r1_grant", 64'(req1_ready), 64'd1);
    step(); req1_valid = 0;
    repeat (4) step();

    // Reset while an operation is executing.
    do_reset();
    step();
    req0_valid = 1; req0_a = 32'hdead_beef; req0_b = 32'h1234_5678; req0_op = 7'd3;
    rsp_ready = 1;
    step(); req0_valid = 0;
    #2 rst = 1;
    @(negedge clk);
    chk("rst_exec_rspv", 64'(rsp_valid), 64'd0);
    chk("rst_exec_alua", 64'(alu_a),     64'd0);
    chk("rst_exec_aluop", 64'(alu_op),   64'd0);
    step(); rst = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("rst_no_rsp", 64'(rsp_valid), 64'd0);
      step();
    end

    // Opcode sweep through requester 1.
    do_reset();
    for (int op = 0; op < 15; op++) begin
      step();
      req1_valid = 1; req1_a = $urandom; req1_b = $urandom; req1_op = 7'(op);
      rsp_ready = 1;
      n = 0;
      @(negedge clk);
      while (!req1_ready && n < 10) begin step(); @(negedge clk); n++; end
      chk("sweep_accept", 64'(req1_ready), 64'd1);
      step(); req1_valid = 0;
    end
    repeat (4) step();

    // Random traffic.
    do_reset();
    for (int blk = 0; blk < 6; blk++) begin
      p0 = $urandom_range(100); p1 = $urandom_range(100); prr = $urandom_range(20, 100);
      auto_drv = 1;
      repeat (250) step();
    end
    auto_drv = 0;
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    repeat (6) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
